// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants, PMAItoReg encoding and the registered control bundle
// used by the ID/EX pipeline stage and its hazard detector.
package id_ex_stage_pkg;

  localparam logic [6:0] R_TYPE       = 7'b0110011;
  localparam logic [6:0] I_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] S_TYPE       = 7'b0100011;
  localparam logic [6:0] B_TYPE       = 7'b1100011;
  localparam logic [6:0] U_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] U_TYPE_AUIPC = 7'b0010111;
  localparam logic [6:0] J_TYPE       = 7'b1101111;

  // Write-back source select; only the memory encoding matters for hazards.
  localparam logic [1:0] PMA_TO_REG_MEM = 2'b10;

  typedef struct packed {
    logic       aluSrc;
    logic [3:0] aluCtrl;
    logic       branch;
    logic       memWrite;
    logic       jal;
    logic       jalr;
    logic [1:0] pmaToReg;
    logic       rdWen;
  } ctrl_t;

  function automatic logic rs1Used(input logic [6:0] opcode);
    return !((opcode == U_TYPE_LUI) || (opcode == U_TYPE_AUIPC) || (opcode == J_TYPE));
  endfunction

  function automatic logic rs2Used(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == S_TYPE) || (opcode == B_TYPE);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX.
import id_ex_stage_pkg::*;

module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [6:0]        opcodeId_i,
  input  logic [REG_AW-1:0] rs1Id_i,
  input  logic [REG_AW-1:0] rs2Id_i,
  input  logic              validId_i,
  input  logic              validEx_i,
  input  logic              rdWenEx_i,
  input  logic [1:0]        pmaToRegEx_i,
  input  logic [REG_AW-1:0] rdEx_i,
  output logic              loadUse_o
);

  logic producerIsLoad;
  logic rs1Match;
  logic rs2Match;

  // A bubble or invalid slot in EX has valid=0, so it can never be the producer.
  assign producerIsLoad = validEx_i && rdWenEx_i && (pmaToRegEx_i == PMA_TO_REG_MEM)
                          && (rdEx_i != '0);
  assign rs1Match = rs1Used(opcodeId_i) && (rs1Id_i == rdEx_i);
  assign rs2Match = rs2Used(opcodeId_i) && (rs2Id_i == rdEx_i);
  assign loadUse_o = producerIsLoad && validId_i && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers decode outputs and operands for EX, inserting
// bubbles on load-use hazards and taken branches, and freezing on downstream hold.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_ID,
  input  logic              valid_ID,
  input  logic [XLEN-1:0]   pc_ID,
  input  logic [XLEN-1:0]   rs1_data_ID,
  input  logic [XLEN-1:0]   rs2_data_ID,
  input  logic [XLEN-1:0]   imm_ID,
  input  logic              ALU_src_ID,
  input  logic [3:0]        ALU_ctrl_ID,
  input  logic              branch_ID,
  input  logic              MemWrite_ID,
  input  logic              jal_ID,
  input  logic              jalr_ID,
  input  logic [1:0]        PMAItoReg_ID,
  input  logic              rd_wen_ID,
  input  logic              flush_EX,
  input  logic              hold_EX,
  output logic              stall_IF_ID,
  output logic              valid_EX,
  output logic [XLEN-1:0]   pc_EX,
  output logic [XLEN-1:0]   rs1_data_EX,
  output logic [XLEN-1:0]   rs2_data_EX,
  output logic [XLEN-1:0]   imm_EX,
  output logic [REG_AW-1:0] rs1_EX,
  output logic [REG_AW-1:0] rs2_EX,
  output logic [REG_AW-1:0] rd_EX,
  output logic              ALU_src_EX,
  output logic [3:0]        ALU_ctrl_EX,
  output logic              branch_EX,
  output logic              MemWrite_EX,
  output logic              jal_EX,
  output logic              jalr_EX,
  output logic [1:0]        PMAItoReg_EX,
  output logic              rd_wen_EX
);

  logic              valid_q,   valid_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [XLEN-1:0]   rs1Data_q, rs1Data_d;
  logic [XLEN-1:0]   rs2Data_q, rs2Data_d;
  logic [XLEN-1:0]   imm_q,     imm_d;
  logic [REG_AW-1:0] rs1_q,     rs1_d;
  logic [REG_AW-1:0] rs2_q,     rs2_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  ctrl_t             ctrl_q,    ctrl_d;

  logic [6:0]        opcodeId;
  logic [REG_AW-1:0] rs1Id;
  logic [REG_AW-1:0] rs2Id;
  logic [REG_AW-1:0] rdId;
  logic              loadUse;
  ctrl_t             ctrlId;
  logic              unusedInstrBits;

  assign opcodeId = instr_ID[6:0];
  assign rdId     = instr_ID[7 +: REG_AW];
  assign rs1Id    = instr_ID[15 +: REG_AW];
  assign rs2Id    = instr_ID[20 +: REG_AW];
  assign unusedInstrBits = ^{instr_ID[31:25], instr_ID[14:12]};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .opcodeId_i   (opcodeId),
    .rs1Id_i      (rs1Id),
    .rs2Id_i      (rs2Id),
    .validId_i    (valid_ID),
    .validEx_i    (valid_q),
    .rdWenEx_i    (ctrl_q.rdWen),
    .pmaToRegEx_i (ctrl_q.pmaToReg),
    .rdEx_i       (rd_q),
    .loadUse_o    (loadUse)
  );

  // A flush redirects IF, so it must never be masked by a stall request.
  assign stall_IF_ID = (loadUse || hold_EX) && !flush_EX && !rst;

  // Side-effecting controls are gated so an invalid ID slot is inert in EX.
  always_comb begin
    ctrlId          = '0;
    ctrlId.aluSrc   = ALU_src_ID;
    ctrlId.aluCtrl  = ALU_ctrl_ID;
    ctrlId.pmaToReg = PMAItoReg_ID;
    ctrlId.branch   = branch_ID   && valid_ID;
    ctrlId.memWrite = MemWrite_ID && valid_ID;
    ctrlId.jal      = jal_ID      && valid_ID;
    ctrlId.jalr     = jalr_ID     && valid_ID;
    ctrlId.rdWen    = rd_wen_ID   && valid_ID;
  end

  // Priority: flush bubble, then hold, then load-use bubble, then normal load.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1Data_d = rs1Data_q;
    rs2Data_d = rs2Data_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    if (flush_EX || (!hold_EX && loadUse)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs1Data_d = '0;
      rs2Data_d = '0;
      imm_d     = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      ctrl_d    = '0;
    end else if (!hold_EX) begin
      valid_d   = valid_ID;
      pc_d      = pc_ID;
      rs1Data_d = rs1_data_ID;
      rs2Data_d = rs2_data_ID;
      imm_d     = imm_ID;
      rs1_d     = rs1Id;
      rs2_d     = rs2Id;
      rd_d      = rdId;
      ctrl_d    = ctrlId;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1Data_q <= '0;
      rs2Data_q <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign valid_EX     = valid_q;
  assign pc_EX        = pc_q;
  assign rs1_data_EX  = rs1Data_q;
  assign rs2_data_EX  = rs2Data_q;
  assign imm_EX       = imm_q;
  assign rs1_EX       = rs1_q;
  assign rs2_EX       = rs2_q;
  assign rd_EX        = rd_q;
  assign ALU_src_EX   = ctrl_q.aluSrc;
  assign ALU_ctrl_EX  = ctrl_q.aluCtrl;
  assign branch_EX    = ctrl_q.branch;
  assign MemWrite_EX  = ctrl_q.memWrite;
  assign jal_EX       = ctrl_q.jal;
  assign jalr_EX      = ctrl_q.jalr;
  assign PMAItoReg_EX = ctrl_q.pmaToReg;
  assign rd_wen_EX    = ctrl_q.rdWen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage: directed hazard/flush/hold scenarios followed
// by randomized traffic, checked against a behavioural model of the EX slot.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
  logic        valid_ID, ALU_src_ID, branch_ID, MemWrite_ID, jal_ID, jalr_ID, rd_wen_ID;
  logic [3:0]  ALU_ctrl_ID;
  logic [1:0]  PMAItoReg_ID;
  logic        flush_EX, hold_EX;
  logic        stall_IF_ID, valid_EX;
  logic [31:0] pc_EX, rs1_data_EX, rs2_data_EX, imm_EX;
  logic [4:0]  rs1_EX, rs2_EX, rd_EX;
  logic        ALU_src_EX, branch_EX, MemWrite_EX, jal_EX, jalr_EX, rd_wen_EX;
  logic [3:0]  ALU_ctrl_EX;
  logic [1:0]  PMAItoReg_EX;

  typedef struct packed {
    logic rst, flush, hold, valid;
    logic [31:0] instr, pc, rs1d, rs2d, imm;
    logic aluSrc;
    logic [3:0] aluCtrl;
    logic branch, memWrite, jal, jalr;
    logic [1:0] pma;
    logic rdWen;
  } stim_t;

  typedef struct packed {
    logic valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0] rs1, rs2, rd;
    logic aluSrc;
    logic [3:0] aluCtrl;
    logic branch, memWrite, jal, jalr;
    logic [1:0] pma;
    logic rdWen;
  } ex_t;

  typedef struct packed {
    logic stall;
    ex_t  ex;
  } exp_t;

  exp_t  sbQ[$];
  ex_t   model = '0;
  stim_t cur = '0;
  logic  lastStall = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .valid_ID(valid_ID), .pc_ID(pc_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID), .imm_ID(imm_ID),
    .ALU_src_ID(ALU_src_ID), .ALU_ctrl_ID(ALU_ctrl_ID), .branch_ID(branch_ID),
    .MemWrite_ID(MemWrite_ID), .jal_ID(jal_ID), .jalr_ID(jalr_ID),
    .PMAItoReg_ID(PMAItoReg_ID), .rd_wen_ID(rd_wen_ID), .flush_EX(flush_EX),
    .hold_EX(hold_EX), .stall_IF_ID(stall_IF_ID), .valid_EX(valid_EX), .pc_EX(pc_EX),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .ALU_src_EX(ALU_src_EX),
    .ALU_ctrl_EX(ALU_ctrl_EX), .branch_EX(branch_EX), .MemWrite_EX(MemWrite_EX),
    .jal_EX(jal_EX), .jalr_EX(jalr_EX), .PMAItoReg_EX(PMAItoReg_EX), .rd_wen_EX(rd_wen_EX)
  );

  always #5 clk = ~clk;

  // Reference model: what the EX slot should read the dependent instruction as.
  function automatic logic hazard(input ex_t e, input stim_t s);
    logic [6:0] op = s.instr[6:0];
    logic [4:0] a = s.instr[19:15];
    logic [4:0] b = s.instr[24:20];
    logic readsA = !(op == U_TYPE_LUI || op == U_TYPE_AUIPC || op == J_TYPE);
    logic readsB = (op == R_TYPE || op == S_TYPE || op == B_TYPE);
    logic pendingLoad = e.valid && e.rdWen && (e.pma == 2'b10) && (e.rd != 5'd0);
    return pendingLoad && s.valid && ((readsA && a == e.rd) || (readsB && b == e.rd));
  endfunction

  function automatic logic expStall(input ex_t e, input stim_t s);
    return (hazard(e, s) || s.hold) && !s.flush && !s.rst;
  endfunction

  function automatic ex_t nextEx(input ex_t e, input stim_t s);
    ex_t n = '0;
    if (s.rst || s.flush) return '0;
    if (s.hold) return e;
    if (hazard(e, s)) return '0;
    n.valid    = s.valid;
    n.pc       = s.pc;
    n.rs1d     = s.rs1d;
    n.rs2d     = s.rs2d;
    n.imm      = s.imm;
    n.rd       = s.instr[11:7];
    n.rs1      = s.instr[19:15];
    n.rs2      = s.instr[24:20];
    n.aluSrc   = s.aluSrc;
    n.aluCtrl  = s.aluCtrl;
    n.pma      = s.pma;
    n.branch   = s.branch   && s.valid;
    n.memWrite = s.memWrite && s.valid;
    n.jal      = s.jal      && s.valid;
    n.jalr     = s.jalr     && s.valid;
    n.rdWen    = s.rdWen    && s.valid;
    return n;
  endfunction

  function automatic stim_t mkInstr(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] pc);
    stim_t s = '0;
    s.valid    = 1'b1;
    s.instr    = {7'd0, rs2, rs1, 3'd0, rd, op};
    s.pc       = pc;
    s.rs1d     = $urandom;
    s.rs2d     = $urandom;
    s.imm      = $urandom;
    s.aluCtrl  = 4'($urandom_range(0, 15));
    s.aluSrc   = !(op == R_TYPE || op == B_TYPE);
    s.rdWen    = !(op == S_TYPE || op == B_TYPE);
    s.memWrite = (op == S_TYPE);
    s.branch   = (op == B_TYPE);
    s.jal      = (op == J_TYPE);
    s.jalr     = (op == OP_JALR);
    s.pma      = (op == I_TYPE_LOAD) ? 2'b10 : ((op == J_TYPE || op == OP_JALR) ? 2'b00 : 2'b01);
    return s;
  endfunction

  function automatic stim_t randomStim();
    logic [6:0] ops [9] = '{R_TYPE, I_TYPE_LOAD, I_TYPE_LOAD, S_TYPE, B_TYPE,
                            U_TYPE_LUI, U_TYPE_AUIPC, J_TYPE, OP_IMM};
    stim_t s = mkInstr(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
    s.instr[31:25] = 7'($urandom);
    s.instr[14:12] = 3'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      s.rdWen    = 1'($urandom);
      s.pma      = 2'($urandom);
      s.memWrite = 1'($urandom);
      s.branch   = 1'($urandom);
      s.jal      = 1'($urandom);
      s.jalr     = 1'($urandom);
    end
    s.valid = ($urandom_range(0, 9) != 0);
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold  = ($urandom_range(0, 6) == 0);
    s.rst   = ($urandom_range(0, 99) == 0);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one ID-stage cycle and records what the stage must present for it.
  task automatic applyStimulus(input stim_t s);
    exp_t item;
    @(negedge clk);
    rst = s.rst; flush_EX = s.flush; hold_EX = s.hold;
    valid_ID = s.valid; instr_ID = s.instr; pc_ID = s.pc;
    rs1_data_ID = s.rs1d; rs2_data_ID = s.rs2d; imm_ID = s.imm;
    ALU_src_ID = s.aluSrc; ALU_ctrl_ID = s.aluCtrl; branch_ID = s.branch;
    MemWrite_ID = s.memWrite; jal_ID = s.jal; jalr_ID = s.jalr;
    PMAItoReg_ID = s.pma; rd_wen_ID = s.rdWen;
    item.stall = expStall(model, s);
    item.ex    = nextEx(model, s);
    sbQ.push_back(item);
    lastStall = item.stall;
    model = item.ex;
    cur = s;
    #3;
  endtask

  // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      #2;
      if (sbQ.size() > 0) begin
        item = sbQ.pop_front();
        checkOutput("stall_IF_ID", 32'(stall_IF_ID), 32'(item.stall));
        @(posedge clk);
        #1;
        checkOutput("valid_EX", 32'(valid_EX), 32'(item.ex.valid));
        checkOutput("pc_EX", pc_EX, item.ex.pc);
        checkOutput("rs1_data_EX", rs1_data_EX, item.ex.rs1d);
        checkOutput("rs2_data_EX", rs2_data_EX, item.ex.rs2d);
        checkOutput("imm_EX", imm_EX, item.ex.imm);
        checkOutput("rs1_EX", 32'(rs1_EX), 32'(item.ex.rs1));
        checkOutput("rs2_EX", 32'(rs2_EX), 32'(item.ex.rs2));
        checkOutput("rd_EX", 32'(rd_EX), 32'(item.ex.rd));
        checkOutput("ALU_src_EX", 32'(ALU_src_EX), 32'(item.ex.aluSrc));
        checkOutput("ALU_ctrl_EX", 32'(ALU_ctrl_EX), 32'(item.ex.aluCtrl));
        checkOutput("branch_EX", 32'(branch_EX), 32'(item.ex.branch));
        checkOutput("MemWrite_EX", 32'(MemWrite_EX), 32'(item.ex.memWrite));
        checkOutput("jal_EX", 32'(jal_EX), 32'(item.ex.jal));
        checkOutput("jalr_EX", 32'(jalr_EX), 32'(item.ex.jalr));
        checkOutput("PMAItoReg_EX", 32'(PMAItoReg_EX), 32'(item.ex.pma));
        checkOutput("rd_wen_EX", 32'(rd_wen_EX), 32'(item.ex.rdWen));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t t;

    // Reset with random inputs on the ports.
    s = randomStim(); s.rst = 1'b1; applyStimulus(s);
    s = randomStim(); s.rst = 1'b1; applyStimulus(s);

    // add x3,x1,x2 at 0x100, then lw x5 behind it.
    s = mkInstr(R_TYPE, 5'd3, 5'd1, 5'd2, 32'h100); s.aluSrc = 1'b1; applyStimulus(s);
    checkOutput("reset_valid_EX", 32'(valid_EX), 32'd0);
    checkOutput("reset_pc_EX", pc_EX, 32'd0);
    checkOutput("reset_rd_wen_EX", 32'(rd_wen_EX), 32'd0);
    s = mkInstr(I_TYPE_LOAD, 5'd5, 5'd2, 5'd0, 32'h104); applyStimulus(s);
    checkOutput("add_pc_EX", pc_EX, 32'h100);
    checkOutput("add_rd_EX", 32'(rd_EX), 32'd3);
    checkOutput("add_rd_wen_EX", 32'(rd_wen_EX), 32'd1);
    checkOutput("add_PMAItoReg_EX", 32'(PMAItoReg_EX), 32'd1);
    checkOutput("add_ALU_src_EX", 32'(ALU_src_EX), 32'd1);

    // Load-use: add x6,x5,x1 stalls once, then loads.
    s = mkInstr(R_TYPE, 5'd6, 5'd5, 5'd1, 32'h108); applyStimulus(s);
    checkOutput("loaduse_stall", 32'(stall_IF_ID), 32'd1);
    applyStimulus(s);
    checkOutput("loaduse_bubble_valid", 32'(valid_EX), 32'd0);
    checkOutput("loaduse_represent_stall", 32'(stall_IF_ID), 32'd0);
    t = mkInstr(OP_IMM, 5'd8, 5'd9, 5'd10, 32'h10c); applyStimulus(t);
    checkOutput("loaduse_after_valid", 32'(valid_EX), 32'd1);
    checkOutput("loaduse_after_rs1_EX", 32'(rs1_EX), 32'd5);

    // Cases that must not stall.
    s = mkInstr(I_TYPE_LOAD, 5'd0, 5'd1, 5'd0, 32'h110); applyStimulus(s);
    s = mkInstr(R_TYPE, 5'd6, 5'd0, 5'd0, 32'h114); applyStimulus(s);
    checkOutput("x0_no_stall", 32'(stall_IF_ID), 32'd0);
    s = mkInstr(I_TYPE_LOAD, 5'd5, 5'd1, 5'd0, 32'h118); applyStimulus(s);
    s = mkInstr(U_TYPE_LUI, 5'd5, 5'd5, 5'd5, 32'h11c); applyStimulus(s);
    checkOutput("lui_no_stall", 32'(stall_IF_ID), 32'd0);
    s = mkInstr(I_TYPE_LOAD, 5'd5, 5'd1, 5'd0, 32'h120); applyStimulus(s);
    s = mkInstr(OP_IMM, 5'd7, 5'd1, 5'd5, 32'h124); applyStimulus(s);
    checkOutput("addi_rs2_no_stall", 32'(stall_IF_ID), 32'd0);

    // Flush with load-use and hold all active.
    s = mkInstr(I_TYPE_LOAD, 5'd5, 5'd1, 5'd0, 32'h128); applyStimulus(s);
    s = mkInstr(R_TYPE, 5'd6, 5'd5, 5'd1, 32'h12c); s.flush = 1'b1; s.hold = 1'b1;
    applyStimulus(s);
    checkOutput("flush_stall", 32'(stall_IF_ID), 32'd0);
    s = mkInstr(OP_IMM, 5'd1, 5'd2, 5'd3, 32'h130); applyStimulus(s);
    checkOutput("flush_bubble_valid", 32'(valid_EX), 32'd0);

    // Three-cycle hold.
    s = mkInstr(R_TYPE, 5'd9, 5'd1, 5'd2, 32'h200); applyStimulus(s);
    s = mkInstr(R_TYPE, 5'd10, 5'd1, 5'd2, 32'h204); s.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      checkOutput("hold_stall", 32'(stall_IF_ID), 32'd1);
      checkOutput("hold_pc_EX", pc_EX, 32'h200);
    end
    s.hold = 1'b0; applyStimulus(s);
    checkOutput("hold_last_pc_EX", pc_EX, 32'h200);
    t = mkInstr(OP_IMM, 5'd1, 5'd2, 5'd3, 32'h208); applyStimulus(t);
    checkOutput("hold_release_pc_EX", pc_EX, 32'h204);

    // Random traffic; a stalled ID instruction is re-presented unchanged.
    for (int i = 0; i < 1500; i++) begin
      if (lastStall) begin
        s = cur;
        t = randomStim();
        s.rst = t.rst; s.flush = t.flush; s.hold = t.hold;
      end else begin
        s = randomStim();
      end
      applyStimulus(s);
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
